// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: ID-stage RAW/WAW scoreboard tracking long-latency int and FP writes,
// with same-cycle clear bypass and an outstanding-write limit.
module id_hazard_scoreboard #(
  parameter int reg_els_p = 32,
  parameter int reg_addr_width_p = 5,
  parameter int max_out_p = 15,
  localparam int cnt_w_lp = $clog2(max_out_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        id_v_i,
  input  logic [reg_addr_width_p-1:0] rs1_i,
  input  logic [reg_addr_width_p-1:0] rs2_i,
  input  logic [reg_addr_width_p-1:0] rs3_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  input  logic                        read_rs1_i,
  input  logic                        read_rs2_i,
  input  logic                        write_rd_i,
  input  logic                        read_frs1_i,
  input  logic                        read_frs2_i,
  input  logic                        read_frs3_i,
  input  logic                        write_frd_i,
  input  logic                        is_long_op_i,
  input  logic                        exe_ready_i,
  input  logic                        int_clr_v_i,
  input  logic [reg_addr_width_p-1:0] int_clr_id_i,
  input  logic                        fp_clr_v_i,
  input  logic [reg_addr_width_p-1:0] fp_clr_id_i,
  output logic                        issue_o,
  output logic                        stall_o,
  output logic [reg_els_p-1:0]        int_sb_o,
  output logic [reg_els_p-1:0]        fp_sb_o,
  output logic [cnt_w_lp-1:0]         out_cnt_o
);
  logic [reg_els_p-1:0] int_sb_q, int_sb_d, fp_sb_q, fp_sb_d;
  logic [reg_els_p-1:0] int_clr, fp_clr, int_live, fp_live, int_set, fp_set;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 int_clr_eff, fp_clr_eff, hazard, full, issue, int_set_v, fp_set_v;
  logic [1:0]           inc, dec;

  always_comb begin
    int_clr = (int_clr_v_i && int_clr_id_i != '0) ? reg_els_p'(1) << int_clr_id_i : '0;
    fp_clr = fp_clr_v_i ? reg_els_p'(1) << fp_clr_id_i : '0;
    int_live = int_sb_q & ~int_clr;
    fp_live = fp_sb_q & ~fp_clr;
    int_clr_eff = |(int_sb_q & int_clr);
    fp_clr_eff = |(fp_sb_q & fp_clr);
    hazard = (read_rs1_i & int_live[rs1_i]) | (read_rs2_i & int_live[rs2_i]) |
             (write_rd_i & int_live[rd_i]) | (read_frs1_i & fp_live[rs1_i]) |
             (read_frs2_i & fp_live[rs2_i]) | (read_frs3_i & fp_live[rs3_i]) |
             (write_frd_i & fp_live[rd_i]);
    // only a clear that actually retires a write frees a slot, so the count cannot overflow
    full = (cnt_q == cnt_w_lp'(max_out_p)) & ~int_clr_eff & ~fp_clr_eff;
    issue = reset_n_i & id_v_i & exe_ready_i & ~hazard & ~(is_long_op_i & full);
    int_set_v = issue & is_long_op_i & write_rd_i & (rd_i != '0);
    fp_set_v = issue & is_long_op_i & write_frd_i;
    int_set = int_set_v ? reg_els_p'(1) << rd_i : '0;
    fp_set = fp_set_v ? reg_els_p'(1) << rd_i : '0;
    int_sb_d = int_live | int_set;
    fp_sb_d = fp_live | fp_set;
    inc = {1'b0, int_set_v} + {1'b0, fp_set_v};
    dec = {1'b0, int_clr_eff} + {1'b0, fp_clr_eff};
    cnt_d = cnt_q + cnt_w_lp'(inc) - cnt_w_lp'(dec);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      int_sb_q <= '0;
      fp_sb_q <= '0;
      cnt_q <= '0;
    end else begin
      int_sb_q <= int_sb_d;
      fp_sb_q <= fp_sb_d;
      cnt_q <= cnt_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (int'(cnt_q) + int'(inc) >= int'(dec)) && (int'(cnt_q) + int'(inc) - int'(dec) <= max_out_p));

  assign issue_o = issue;
  assign stall_o = reset_n_i & id_v_i & ~issue;
  assign int_sb_o = int_sb_q;
  assign fp_sb_o = fp_sb_q;
  assign out_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed vector table, corner sequences and random stimulus
// against an array-based model of the pending-write scoreboard.
module tb_id_hazard_scoreboard;
  localparam int N = 32, MO = 15;
  logic clk_i = 0, reset_n_i = 0;
  logic id_v_i, read_rs1_i, read_rs2_i, write_rd_i, read_frs1_i, read_frs2_i, read_frs3_i, write_frd_i;
  logic is_long_op_i, exe_ready_i, int_clr_v_i, fp_clr_v_i, issue_o, stall_o;
  logic [4:0] rs1_i, rs2_i, rs3_i, rd_i, int_clr_id_i, fp_clr_id_i;
  logic [N-1:0] int_sb_o, fp_sb_o;
  logic [3:0] out_cnt_o;

  typedef struct {
    logic id_v; logic [4:0] rs1, rs2, rs3, rd;
    logic r1, r2, w, f1, f2, f3, fw, lng, rdy, icv; logic [4:0] icid; logic fcv; logic [4:0] fcid;
  } in_t;
  typedef struct { in_t i; logic e_issue, e_stall; int e_cnt; } vec_t;

  id_hazard_scoreboard dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .id_v_i(id_v_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .rd_i(rd_i),
    .read_rs1_i(read_rs1_i), .read_rs2_i(read_rs2_i), .write_rd_i(write_rd_i),
    .read_frs1_i(read_frs1_i), .read_frs2_i(read_frs2_i), .read_frs3_i(read_frs3_i),
    .write_frd_i(write_frd_i), .is_long_op_i(is_long_op_i), .exe_ready_i(exe_ready_i),
    .int_clr_v_i(int_clr_v_i), .int_clr_id_i(int_clr_id_i),
    .fp_clr_v_i(fp_clr_v_i), .fp_clr_id_i(fp_clr_id_i),
    .issue_o(issue_o), .stall_o(stall_o), .int_sb_o(int_sb_o), .fp_sb_o(fp_sb_o),
    .out_cnt_o(out_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  bit m_int[N], m_fp[N];
  int m_cnt = 0;
  vec_t tv[18];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t nop();
    in_t x = '{default: '0};
    x.rdy = 1;
    return x;
  endfunction
  function automatic in_t lint(int r);
    in_t x = nop(); x.id_v = 1; x.rd = 5'(r); x.w = 1; x.lng = 1; return x;
  endfunction
  function automatic in_t lfp(int r);
    in_t x = nop(); x.id_v = 1; x.rd = 5'(r); x.fw = 1; x.lng = 1; return x;
  endfunction
  function automatic in_t rdi(int r);
    in_t x = nop(); x.id_v = 1; x.rs1 = 5'(r); x.r1 = 1; return x;
  endfunction
  function automatic in_t rdf1(int r);
    in_t x = nop(); x.id_v = 1; x.rs1 = 5'(r); x.f1 = 1; return x;
  endfunction
  function automatic in_t rdf3(int r);
    in_t x = nop(); x.id_v = 1; x.rs3 = 5'(r); x.f3 = 1; return x;
  endfunction
  function automatic in_t wic(in_t x, int r);
    x.icv = 1; x.icid = 5'(r); return x;
  endfunction
  function automatic in_t wfc(in_t x, int r);
    x.fcv = 1; x.fcid = 5'(r); return x;
  endfunction
  function automatic in_t nrdy(in_t x);
    x.rdy = 0; return x;
  endfunction

  task automatic drive(in_t x);
    id_v_i = x.id_v; rs1_i = x.rs1; rs2_i = x.rs2; rs3_i = x.rs3; rd_i = x.rd;
    read_rs1_i = x.r1; read_rs2_i = x.r2; write_rd_i = x.w;
    read_frs1_i = x.f1; read_frs2_i = x.f2; read_frs3_i = x.f3; write_frd_i = x.fw;
    is_long_op_i = x.lng; exe_ready_i = x.rdy;
    int_clr_v_i = x.icv; int_clr_id_i = x.icid; fp_clr_v_i = x.fcv; fp_clr_id_i = x.fcid;
  endtask

  function automatic bit pend_i(int r, in_t x);
    return r != 0 && m_int[r] && !(x.icv && int'(x.icid) == r);
  endfunction
  function automatic bit pend_f(int r, in_t x);
    return m_fp[r] && !(x.fcv && int'(x.fcid) == r);
  endfunction

  function automatic logic [N-1:0] pack(bit a[N]);
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = a[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_int[k] = 0; m_fp[k] = 0; end
    m_cnt = 0;
  endtask

  task automatic step(input in_t x, output logic iss, output logic stl);
    bit hz, ci, cf, full, e_iss;
    drive(x);
    #4;
    hz = (x.r1 && pend_i(x.rs1, x)) || (x.r2 && pend_i(x.rs2, x)) || (x.w && pend_i(x.rd, x)) ||
         (x.f1 && pend_f(x.rs1, x)) || (x.f2 && pend_f(x.rs2, x)) || (x.f3 && pend_f(x.rs3, x)) ||
         (x.fw && pend_f(x.rd, x));
    ci = x.icv && x.icid != 0 && m_int[x.icid];
    cf = x.fcv && m_fp[x.fcid];
    full = m_cnt == MO && !ci && !cf;
    e_iss = x.id_v && x.rdy && !hz && !(x.lng && full);
    iss = issue_o; stl = stall_o;
    chk("issue", 64'(issue_o), 64'(e_iss));
    chk("stall", 64'(stall_o), 64'(x.id_v && !e_iss));
    chk("int_sb", 64'(int_sb_o), 64'(pack(m_int)));
    chk("fp_sb", 64'(fp_sb_o), 64'(pack(m_fp)));
    chk("out_cnt", 64'(out_cnt_o), 64'(m_cnt));
    if (ci) begin m_int[x.icid] = 0; m_cnt--; end
    if (cf) begin m_fp[x.fcid] = 0; m_cnt--; end
    if (e_iss && x.lng && x.w && x.rd != 0) begin m_int[x.rd] = 1; m_cnt++; end
    if (e_iss && x.lng && x.fw) begin m_fp[x.rd] = 1; m_cnt++; end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic iss, stl;
    in_t x;
    tv[0]  = '{lint(5), 1, 0, 1};
    tv[1]  = '{rdi(5), 0, 1, 1};
    tv[2]  = '{rdi(5), 0, 1, 1};
    tv[3]  = '{wic(rdi(5), 5), 1, 0, 0};
    tv[4]  = '{lint(0), 1, 0, 0};
    tv[5]  = '{lfp(3), 1, 0, 1};
    tv[6]  = '{wfc(lfp(3), 3), 1, 0, 1};
    tv[7]  = '{lint(7), 1, 0, 2};
    tv[8]  = '{lfp(7), 1, 0, 3};
    tv[9]  = '{wic(rdf3(7), 7), 0, 1, 2};
    tv[10] = '{wfc(rdf3(7), 7), 1, 0, 1};
    tv[11] = '{nrdy(rdi(1)), 0, 1, 1};
    tv[12] = '{nop(), 0, 0, 1};
    tv[13] = '{wic(nop(), 9), 0, 0, 1};
    tv[14] = '{wfc(nop(), 3), 0, 0, 0};
    tv[15] = '{lfp(0), 1, 0, 1};
    tv[16] = '{rdf1(0), 0, 1, 1};
    tv[17] = '{wfc(nop(), 0), 0, 0, 0};

    x = rdi(0);
    drive(x);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_issue", 64'(issue_o), 0);
    chk("rst_stall", 64'(stall_o), 0);
    chk("rst_cnt", 64'(out_cnt_o), 0);
    chk("rst_int_sb", 64'(int_sb_o), 0);
    reset_n_i = 1;
    model_reset();

    for (int k = 0; k < 18; k++) begin
      step(tv[k].i, iss, stl);
      chk($sformatf("tv%0d_issue", k), 64'(iss), 64'(tv[k].e_issue));
      chk($sformatf("tv%0d_stall", k), 64'(stl), 64'(tv[k].e_stall));
      chk($sformatf("tv%0d_cnt", k), 64'(out_cnt_o), 64'(tv[k].e_cnt));
    end

    for (int r = 1; r <= 15; r++) step(lint(r), iss, stl);
    chk("fill_cnt", 64'(out_cnt_o), 15);
    step(lint(16), iss, stl);
    chk("full_stall", 64'(stl), 1);
    step(wic(lint(16), 1), iss, stl);
    chk("full_clr_issue", 64'(iss), 1);
    chk("full_clr_cnt", 64'(out_cnt_o), 15);
    for (int r = 2; r <= 16; r++) step(wic(nop(), r), iss, stl);
    chk("drain_cnt", 64'(out_cnt_o), 0);

    step(lint(5), iss, stl);
    step(lfp(9), iss, stl);
    drive(rdi(5));
    #3;
    reset_n_i = 0;
    #1;
    chk("async_int_sb", 64'(int_sb_o), 0);
    chk("async_fp_sb", 64'(fp_sb_o), 0);
    chk("async_cnt", 64'(out_cnt_o), 0);
    chk("async_issue", 64'(issue_o), 0);
    chk("async_stall", 64'(stall_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1;
    step(wic(nop(), 5), iss, stl);
    chk("post_rst_clr_cnt", 64'(out_cnt_o), 0);
    chk("post_rst_clr_sb", 64'(int_sb_o), 0);

    for (int n = 0; n < 2000; n++) begin
      x = nop();
      x.id_v = $urandom_range(0, 9) < 8;
      x.rdy = $urandom_range(0, 9) < 8;
      x.rs1 = 5'($urandom_range(0, 7)); x.rs2 = 5'($urandom_range(0, 7));
      x.rs3 = 5'($urandom_range(0, 7)); x.rd = 5'($urandom_range(0, 7));
      x.r1 = 1'($urandom); x.r2 = 1'($urandom);
      x.f1 = 1'($urandom); x.f2 = 1'($urandom); x.f3 = 1'($urandom);
      x.lng = 1'($urandom);
      x.w = 1'($urandom);
      x.fw = x.lng ? !x.w : 1'($urandom);
      x.icv = $urandom_range(0, 9) < 4; x.icid = 5'($urandom_range(0, 7));
      x.fcv = $urandom_range(0, 9) < 4; x.fcid = 5'($urandom_range(0, 7));
      step(x, iss, stl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_hazard_scoreboard.md
ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 Parameters: reg_els_p, 32, registers per file; reg_addr_width_p, 5, register index width; max_out_p, 15, outstanding long-latency writes allowed (count width = $clog2(max_out_p+1)).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 id_v_i  in  1  decoded instruction valid in ID stage.
REQ-005 rs1_i, rs2_i, rs3_i, rd_i  in  reg_addr_width_p each  register fields of the decoded instruction.
REQ-006 read_rs1_i, read_rs2_i, write_rd_i  in  1 each  integer-file usage flags from the decoder.
REQ-007 read_frs1_i, read_frs2_i, read_frs3_i, write_frd_i  in  1 each  FP-file usage flags from the decoder.
REQ-008 is_long_op_i  in  1  instruction writes its destination with variable latency (idiv, fdiv, fsqrt, remote load, amo).
REQ-009 exe_ready_i  in  1  EXE stage accepts an instruction this cycle.
REQ-010 int_clr_v_i, int_clr_id_i  in  1, reg_addr_width_p  integer writeback completion.
REQ-011 fp_clr_v_i, fp_clr_id_i  in  1, reg_addr_width_p  FP writeback completion.
REQ-012 issue_o  out  1  instruction leaves ID this cycle.
REQ-013 stall_o  out  1  id_v_i held due to hazard, count limit, or !exe_ready_i.
REQ-014 int_sb_o, fp_sb_o  out  reg_els_p each  pending-write bit vectors.
REQ-015 out_cnt_o  out  count width  outstanding long-latency writes.

Function
REQ-016 Hazard = any enabled source (rs1/rs2 int; frs1/2/3 FP) or enabled destination (WAW) whose scoreboard bit is set and not cleared this cycle for that same file and index.
REQ-017 Clear bypass: a clear in cycle N removes the hazard for that register in cycle N (combinational).
REQ-018 Integer index 0 never scored, never hazards; FP index 0 is a normal register.
REQ-019 issue_o = id_v_i & exe_ready_i & !hazard & !(is_long_op_i & full); stall_o = id_v_i & !issue_o.
REQ-020 full = (out_cnt_o == max_out_p) & no clear this cycle.
REQ-021 On issue_o & is_long_op_i & write_rd_i & rd_i!=0: int_sb_o[rd_i] set next cycle; with write_frd_i: fp_sb_o[rd_i] set.
REQ-022 Clear with matching set in the same cycle and same file/index: bit ends set (set wins).
REQ-023 Clear of an unset bit: no change to bit, out_cnt_o not decremented; no error output.
REQ-024 out_cnt_o += 1 per scored issue, -= 1 per effective clear (int and fp clears each count); simultaneous ±: net; never wraps (assertion on underflow/overflow in simulation).
REQ-025 Both clear ports may fire in one cycle, any indices; independent.
REQ-026 Non-long-op instructions never modify state; combinational path from inputs to issue_o/stall_o, zero latency.

Reset
REQ-027 reset_n_i low: int_sb_o=0, fp_sb_o=0, out_cnt_o=0 immediately, independent of clk_i.
REQ-028 During reset issue_o and stall_o are 0 regardless of id_v_i; clears ignored.
REQ-029 Reset mid-operation discards all pending bits; later clears for discarded writes are no-ops per REQ-023.

Verification
REQ-030 Issue long-op rd=5 (int), next cycle rs1=5 read -> stall_o=1 until int_clr_v_i/id=5, issue_o=1 in that same clear cycle.
REQ-031 Long-op with rd=0, write_rd_i=1 -> int_sb_o stays 0, out_cnt_o stays 0.
REQ-032 Issue 15 long-ops (distinct rd) -> out_cnt_o=15; 16th long-op stalls; same-cycle clear lets it issue, out_cnt_o remains 15.
REQ-033 fp_sb_o[3]=1, cycle with fp_clr id=3 and new FP long-op issue rd=3 -> fp_sb_o[3]=1, out_cnt_o unchanged.
REQ-034 FMA reading frs3=7 with fp_sb_o[7]=1 while int_sb_o[7]=1 cleared -> still stalls (files independent).
REQ-035 Assert reset_n_i low between clock edges with bits set -> outputs zero before next edge; post-reset clear id=5 -> no change.
